// File: rtl/alu_control.sv
// ALU-operation decoder: maps ALUOp class plus Opcode/AlterOp fields to a 4-bit ALU select.
// Latency: out/bad_op combinational (0 cycles); out_q registered copy (1 cycle). No backpressure.
module alu_control #(
    parameter logic [3:0] DEFAULT_OP = 4'b0000
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [1:0] ALUOp,
    input  logic [4:0] Opcode,
    input  logic [4:0] AlterOp,
    output logic [3:0] out,
    output logic [3:0] out_q,
    output logic       bad_op
);

    logic [3:0] out_d;

    always_comb begin
        out    = DEFAULT_OP;
        bad_op = 1'b0;
        case (ALUOp)
            2'b00: out = 4'b0000;
            2'b01: out = 4'b0001;
            2'b10: begin
                case (Opcode)
                    5'b00000: out = 4'b0000;
                    5'b00001: out = 4'b0001;
                    5'b00010: out = 4'b0111;
                    5'b00011: out = 4'b0101;
                    5'b00100: out = 4'b0110;
                    5'b00101: out = 4'b0010;
                    5'b01000: out = 4'b0101;
                    5'b01001: out = 4'b0111;
                    5'b01010: out = 4'b0110;
                    5'b01011: out = 4'b0000;
                    5'b01100: out = 4'b0010;
                    5'b01101: out = 4'b0011;
                    5'b01110: out = 4'b0100;
                    5'b01111: out = 4'b1011;
                    5'b10000: out = 4'b1000;
                    5'b10001: out = 4'b1010;
                    5'b10010: out = 4'b1011;
                    5'b10011: out = 4'b1011;
                    5'b10111: out = 4'b0000;
                    5'b11000: out = 4'b1111;
                    5'b11001: out = 4'b0000;
                    5'b11101: out = 4'b1110;
                    default: begin
                        out    = DEFAULT_OP;
                        bad_op = 1'b1;
                    end
                endcase
            end
            2'b11: begin
                case (AlterOp)
                    5'b00000: out = 4'b0000;
                    5'b00001: out = 4'b0001;
                    5'b00110: out = 4'b0011;
                    5'b00111: out = 4'b0100;
                    5'b01101: out = 4'b1100;
                    5'b01110: out = 4'b1101;
                    default: begin
                        out    = DEFAULT_OP;
                        bad_op = 1'b1;
                    end
                endcase
            end
            // Unknown select (X/Z in 4-state sim) falls back to the safe op.
            default: out = DEFAULT_OP;
        endcase
    end

    assign out_d = out;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            out_q <= 4'b0000;
        end else begin
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_alu_control.sv
// Directed table-driven bench for alu_control plus reset / mid-cycle sequences.
module tb_alu_control;

    logic       CLK;
    logic       Reset;
    logic [1:0] ALUOp;
    logic [4:0] Opcode;
    logic [4:0] AlterOp;
    logic [3:0] out;
    logic [3:0] out_q;
    logic       bad_op;

    int checks;
    int failures;

    alu_control #(.DEFAULT_OP(4'b0000)) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .ALUOp  (ALUOp),
        .Opcode (Opcode),
        .AlterOp(AlterOp),
        .out    (out),
        .out_q  (out_q),
        .bad_op (bad_op)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] aluop;
        logic [4:0] opcode;
        logic [4:0] alterop;
        logic [3:0] exp_out;
        logic       exp_bad;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] a, input logic [4:0] o, input logic [4:0] t,
                       input logic [3:0] e, input logic b);
        vec_t v;
        v.aluop = a; v.opcode = o; v.alterop = t; v.exp_out = e; v.exp_bad = b;
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // ALUOp=10 opcode table
        add(2'b10, 5'b00000, 5'b00000, 4'b0000, 1'b0);
        add(2'b10, 5'b00001, 5'b00000, 4'b0001, 1'b0);
        add(2'b10, 5'b00010, 5'b00000, 4'b0111, 1'b0);
        add(2'b10, 5'b00011, 5'b00000, 4'b0101, 1'b0);
        add(2'b10, 5'b00100, 5'b00000, 4'b0110, 1'b0);
        add(2'b10, 5'b00101, 5'b00000, 4'b0010, 1'b0);
        add(2'b10, 5'b01000, 5'b00000, 4'b0101, 1'b0);
        add(2'b10, 5'b01001, 5'b00000, 4'b0111, 1'b0);
        add(2'b10, 5'b01010, 5'b00000, 4'b0110, 1'b0);
        add(2'b10, 5'b01011, 5'b00000, 4'b0000, 1'b0);
        add(2'b10, 5'b01100, 5'b00000, 4'b0010, 1'b0);
        add(2'b10, 5'b01101, 5'b00000, 4'b0011, 1'b0);
        add(2'b10, 5'b01110, 5'b00000, 4'b0100, 1'b0);
        add(2'b10, 5'b01111, 5'b00000, 4'b1011, 1'b0);
        add(2'b10, 5'b10000, 5'b00000, 4'b1000, 1'b0);
        add(2'b10, 5'b10001, 5'b00000, 4'b1010, 1'b0);
        add(2'b10, 5'b10010, 5'b00000, 4'b1011, 1'b0);
        add(2'b10, 5'b10011, 5'b00000, 4'b1011, 1'b0);
        add(2'b10, 5'b10111, 5'b00000, 4'b0000, 1'b0);
        add(2'b10, 5'b11000, 5'b00000, 4'b1111, 1'b0);
        add(2'b10, 5'b11001, 5'b00000, 4'b0000, 1'b0);
        add(2'b10, 5'b11101, 5'b00000, 4'b1110, 1'b0);
        // fixed classes ignore both fields
        add(2'b00, 5'b11101, 5'b01110, 4'b0000, 1'b0);
        add(2'b01, 5'b11101, 5'b01110, 4'b0001, 1'b0);
        add(2'b00, 5'b00110, 5'b11111, 4'b0000, 1'b0);
        add(2'b01, 5'b00110, 5'b11111, 4'b0001, 1'b0);
        // ALUOp=11 alter table; Opcode set to a value that would decode differently
        add(2'b11, 5'b11000, 5'b00000, 4'b0000, 1'b0);
        add(2'b11, 5'b11000, 5'b00001, 4'b0001, 1'b0);
        add(2'b11, 5'b11000, 5'b00111, 4'b0100, 1'b0);
        add(2'b11, 5'b11000, 5'b00110, 4'b0011, 1'b0);
        add(2'b11, 5'b11000, 5'b01101, 4'b1100, 1'b0);
        add(2'b11, 5'b11000, 5'b01110, 4'b1101, 1'b0);
        // unsupported encodings
        add(2'b10, 5'b00110, 5'b00001, 4'b0000, 1'b1);
        add(2'b10, 5'b00111, 5'b00001, 4'b0000, 1'b1);
        add(2'b10, 5'b11111, 5'b00001, 4'b0000, 1'b1);
        add(2'b10, 5'b11100, 5'b00001, 4'b0000, 1'b1);
        add(2'b11, 5'b00001, 5'b11111, 4'b0000, 1'b1);
        add(2'b11, 5'b00001, 5'b00010, 4'b0000, 1'b1);

        // Reset asserted from time 0: out_q cleared, decode still live
        Reset   = 1'b1;
        ALUOp   = 2'b10;
        Opcode  = 5'b11101;
        AlterOp = 5'b00000;
        #3;
        chk("rst_out_q", 0, 32'(out_q), 32'h0);
        chk("rst_out", 0, 32'(out), 32'he);
        chk("rst_bad", 0, 32'(bad_op), 32'h0);
        @(posedge CLK); #1;
        chk("rst_hold_out_q", 0, 32'(out_q), 32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK); #1;
        chk("rel_out_q", 0, 32'(out_q), 32'he);

        // Table sweep: combinational check, then registered copy after the edge
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            ALUOp   = vecs[i].aluop;
            Opcode  = vecs[i].opcode;
            AlterOp = vecs[i].alterop;
            #1;
            chk("out", i, 32'(out), 32'(vecs[i].exp_out));
            chk("bad_op", i, 32'(bad_op), 32'(vecs[i].exp_bad));
            @(posedge CLK); #1;
            chk("out_q", i, 32'(out_q), 32'(vecs[i].exp_out));
        end

        // Mid-cycle async reset with out=1110
        @(negedge CLK);
        ALUOp  = 2'b10;
        Opcode = 5'b11101;
        @(posedge CLK); #1;
        chk("pre_rst_out_q", 0, 32'(out_q), 32'he);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_rst_out_q", 0, 32'(out_q), 32'h0);
        chk("mid_rst_out", 0, 32'(out), 32'he);
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        chk("post_rel_out_q", 0, 32'(out_q), 32'h0);
        @(posedge CLK); #1;
        chk("post_rel_edge_out_q", 0, 32'(out_q), 32'he);

        // Opcode change between edges: out tracks, out_q waits for the edge
        @(negedge CLK);
        Opcode = 5'b00001;
        #1;
        chk("chg_out_a", 0, 32'(out), 32'h1);
        @(posedge CLK); #1;
        chk("chg_out_q_a", 0, 32'(out_q), 32'h1);
        #2;
        Opcode = 5'b01101;
        #1;
        chk("chg_out_b", 0, 32'(out), 32'h3);
        chk("chg_out_q_hold", 0, 32'(out_q), 32'h1);
        @(posedge CLK); #1;
        chk("chg_out_q_b", 0, 32'(out_q), 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
